// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-requester UART byte arbiter.
// FSM state encoding, word/byte geometry and the byte-count clamp.
package uart_arb_pkg;

    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 64;
    localparam int MAX_BYTES = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_START   = 3'd2;
    localparam logic [2:0] ST_WAIT_HI = 3'd3;
    localparam logic [2:0] ST_WAIT_LO = 3'd4;
    localparam logic [2:0] ST_FIN     = 3'd5;
    localparam logic [2:0] ST_CSUM    = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        LOAD    = ST_LOAD,
        START   = ST_START,
        WAIT_HI = ST_WAIT_HI,
        WAIT_LO = ST_WAIT_LO,
        FIN     = ST_FIN,
        CSUM    = ST_CSUM
    } state_e;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        return (len > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : len;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the word requesters, the arbiter and the byte transmitter.
// slave = arbiter side, master = requester/transmitter side.
interface uart_tx_arbiter_if;
    import uart_arb_pkg::*;

    logic              iREQ0;
    logic [WORD_W-1:0] iDATA0;
    logic [3:0]        iLEN0;
    logic              oDONE0;
    logic              iREQ1;
    logic [WORD_W-1:0] iDATA1;
    logic [3:0]        iLEN1;
    logic              oDONE1;
    logic [1:0]        oGRANT;
    logic [BYTE_W-1:0] oTXD_DATA;
    logic              oTXD_Start;
    logic              iTXD_Busy;
    logic              oERR;

    modport slave (
        input  iREQ0, iDATA0, iLEN0,
        input  iREQ1, iDATA1, iLEN1,
        input  iTXD_Busy,
        output oDONE0, oDONE1, oGRANT,
        output oTXD_DATA, oTXD_Start, oERR
    );

    modport master (
        output iREQ0, iDATA0, iLEN0,
        output iREQ1, iDATA1, iLEN1,
        output iTXD_Busy,
        input  oDONE0, oDONE1, oGRANT,
        input  oTXD_DATA, oTXD_Start, oERR
    );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one RS232 byte transmitter between two
// word requesters; sends 1..8 bytes MSB-first with a Start/Busy handshake.
// Ports: iCLK, iRST (sync, active high), bus (uart_tx_arbiter_if.slave).
// Build option UART_TX_CHECKSUM_EN appends an XOR checksum byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int START_TMO = 1024,
    parameter int TMO_W     = 11
) (
    input  logic              iCLK,
    input  logic              iRST,
    uart_tx_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [1:0]        grant_q, grant_d;
    logic              start_q, start_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              err_q, err_d;
    logic              to_fin;
`ifdef UART_TX_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
    logic              csum_ph_q, csum_ph_d;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        start_d = 1'b0;
        err_d   = err_q;
        to_fin  = 1'b0;
`ifdef UART_TX_CHECKSUM_EN
        csum_d    = csum_q;
        csum_ph_d = csum_ph_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.iREQ0 | bus.iREQ1) begin
                    // On contention favour whoever was not served last
                    owner_d = (bus.iREQ0 & bus.iREQ1) ? ~last_q : bus.iREQ1;
                    grant_d = owner_d ? 2'b10 : 2'b01;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d = owner_q ? bus.iDATA1 : bus.iDATA0;
                cnt_d   = clamp_len(owner_q ? bus.iLEN1 : bus.iLEN0);
`ifdef UART_TX_CHECKSUM_EN
                csum_d    = '0;
                csum_ph_d = 1'b0;
`endif
                if (cnt_d == 4'd0) begin
                    to_fin  = 1'b1;
                    state_d = FIN;
                end else begin
                    state_d = START;
                end
            end
            START: begin
                if (!bus.iTXD_Busy) begin
                    start_d = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.iTXD_Busy) begin
                    state_d = WAIT_LO;
                end else if (tmo_q == TMO_W'(START_TMO - 1)) begin
                    // Transmitter never accepted the byte: drop the rest
                    err_d   = 1'b1;
                    to_fin  = 1'b1;
                    state_d = FIN;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            WAIT_LO: begin
                if (!bus.iTXD_Busy) begin
`ifdef UART_TX_CHECKSUM_EN
                    if (csum_ph_q) begin
                        to_fin  = 1'b1;
                        state_d = FIN;
                    end else begin
                        shift_d = {shift_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                        cnt_d   = cnt_q - 4'd1;
                        csum_d  = csum_q ^ shift_q[WORD_W-1 -: BYTE_W];
                        state_d = (cnt_d == 4'd0) ? CSUM : START;
                    end
`else
                    shift_d = {shift_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                    cnt_d   = cnt_q - 4'd1;
                    if (cnt_d == 4'd0) begin
                        to_fin  = 1'b1;
                        state_d = FIN;
                    end else begin
                        state_d = START;
                    end
`endif
                end
            end
`ifdef UART_TX_CHECKSUM_EN
            CSUM: begin
                shift_d   = {csum_q, {(WORD_W-BYTE_W){1'b0}}};
                csum_ph_d = 1'b1;
                state_d   = START;
            end
`endif
            FIN: begin
                grant_d = 2'b00;
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done0_d = to_fin & ~owner_q;
        done1_d = to_fin & owner_q;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
            start_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
            csum_q    <= '0;
            csum_ph_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            start_q <= start_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err_q   <= err_d;
`ifdef UART_TX_CHECKSUM_EN
            csum_q    <= csum_d;
            csum_ph_q <= csum_ph_d;
`endif
        end
    end

    assign bus.oGRANT     = grant_q;
    assign bus.oTXD_Start = start_q;
    assign bus.oTXD_DATA  = shift_q[WORD_W-1 -: BYTE_W];
    assign bus.oDONE0     = done0_q;
    assign bus.oDONE1     = done1_q;
    assign bus.oERR       = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transmitter model, vector table,
// directed corner sequences and randomized packets vs a byte-list model.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

`ifdef UART_TX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.START_TMO(16), .TMO_W(5)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Transmitter: Busy rises the cycle after Start, stays high 10 cycles
    logic tx_on  = 1'b1;
    logic busy_m = 1'b0;
    int   bcnt   = 0;
    assign bus.iTXD_Busy = busy_m;
    always @(posedge clk) begin
        if (tx_on && bus.oTXD_Start) begin
            busy_m <= 1'b1;
            bcnt   <= 10;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) busy_m <= 1'b0;
        end
    end

    // Captured {grant, byte} at every Start pulse
    logic [9:0] cap_q[$];
    always @(negedge clk) begin
        if (bus.oTXD_Start) cap_q.push_back({bus.oGRANT, bus.oTXD_DATA});
    end

    logic [9:0] exp_q[$];
    int model_last = 1;

    function automatic void model_pkt(input int who, input logic [63:0] d,
                                      input logic [3:0] l);
        int n;
        logic [7:0] x;
        logic [1:0] g;
        n = (l > 4'd8) ? 8 : int'(l);
        x = 8'h00;
        g = (who == 1) ? 2'b10 : 2'b01;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({g, d[63-8*k -: 8]});
            x = x ^ d[63-8*k -: 8];
        end
        if (CS == 1 && n > 0) exp_q.push_back({g, x});
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic xfer(input bit r0, input bit r1,
                        input logic [63:0] d0, input logic [63:0] d1,
                        input logic [3:0] l0, input logic [3:0] l1,
                        output int first, output int nb);
        int ord[$];
        int efirst;
        int cyc;
        bit p0, p1;
        exp_q.delete();
        cap_q.delete();
        efirst = (r0 && r1) ? 1 - model_last : (r1 ? 1 : 0);
        if (efirst == 0) begin
            if (r0) model_pkt(0, d0, l0);
            if (r1) model_pkt(1, d1, l1);
        end else begin
            model_pkt(1, d1, l1);
            if (r0) model_pkt(0, d0, l0);
        end
        if (!(r0 && r1)) model_last = efirst;
        @(negedge clk);
        bus.iDATA0 = d0; bus.iLEN0 = l0;
        bus.iDATA1 = d1; bus.iLEN1 = l1;
        bus.iREQ0 = r0; bus.iREQ1 = r1;
        p0 = r0; p1 = r1; cyc = 0;
        while ((p0 || p1) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (bus.oDONE0) begin ord.push_back(0); bus.iREQ0 = 1'b0; p0 = 0; end
            if (bus.oDONE1) begin ord.push_back(1); bus.iREQ1 = 1'b0; p1 = 0; end
        end
        chk("xfer_pending", {62'b0, p0, p1}, 64'd0);
        bus.iREQ0 = 1'b0;
        bus.iREQ1 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.oDONE0) ord.push_back(0);
            if (bus.oDONE1) ord.push_back(1);
        end
        chk("done_cnt", ord.size(), int'(r0) + int'(r1));
        first = (ord.size() > 0) ? ord[0] : -1;
        nb = cap_q.size();
        chk("first_model", first, efirst);
        chk("byte_cnt", cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            chk($sformatf("byte%0d", i), cap_q[i], exp_q[i]);
    endtask

    typedef struct {
        bit          r0;
        bit          r1;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [3:0]  l0;
        logic [3:0]  l1;
        int          efirst;
        int          enb;
    } vec_t;

    vec_t vt[6];

    initial begin
        int f, nb, cyc, dn, r;
        logic [1:0] g1;
        logic [63:0] rd0, rd1;
        logic [3:0] rl0, rl1;

        vt[0] = '{1'b1, 1'b1, 64'h1122334455667788, 64'h99AABBCCDDEEFF00,
                  4'd3, 4'd2, 0, 5 + 2*CS};
        vt[1] = '{1'b1, 1'b1, 64'hA1A2A3A4A5A6A7A8, 64'hB1B2B3B4B5B6B7B8,
                  4'd1, 4'd4, 0, 5 + 2*CS};
        vt[2] = '{1'b1, 1'b0, 64'h0102030405060708, 64'h0,
                  4'd8, 4'd0, 0, 8 + CS};
        vt[3] = '{1'b0, 1'b1, 64'h0, 64'hDEADBEEFCAFEF00D,
                  4'd0, 4'd0, 1, 0};
        vt[4] = '{1'b0, 1'b1, 64'h0, 64'hF0E1D2C3B4A59687,
                  4'd0, 4'd15, 1, 8 + CS};
        vt[5] = '{1'b1, 1'b0, 64'hAA55000000000000, 64'h0,
                  4'd2, 4'd0, 0, 2 + CS};

        rst = 1'b1;
        bus.iREQ0 = 1'b0; bus.iDATA0 = '0; bus.iLEN0 = '0;
        bus.iREQ1 = 1'b0; bus.iDATA1 = '0; bus.iLEN1 = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {bus.oGRANT, bus.oTXD_DATA, bus.oTXD_Start,
                           bus.oDONE0, bus.oDONE1, bus.oERR}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            xfer(vt[i].r0, vt[i].r1, vt[i].d0, vt[i].d1,
                 vt[i].l0, vt[i].l1, f, nb);
            chk($sformatf("vec%0d_first", i), f, vt[i].efirst);
            chk($sformatf("vec%0d_nbytes", i), nb, vt[i].enb);
        end

        // Start latency and grant visibility
        cap_q.delete();
        @(negedge clk);
        bus.iDATA0 = 64'hC300000000000000; bus.iLEN0 = 4'd1; bus.iREQ0 = 1'b1;
        cyc = 0; g1 = 2'b00;
        while (!bus.oTXD_Start && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) g1 = bus.oGRANT;
        end
        chk("latency", cyc, 3);
        chk("grant_load", g1, 2'b01);
        cyc = 0;
        while (!bus.oDONE0 && cyc < 100) begin @(negedge clk); cyc++; end
        chk("lat_done", bus.oDONE0, 1'b1);
        bus.iREQ0 = 1'b0;
        repeat (2) @(negedge clk);
        model_last = 0;

        // Zero-length packet
        cap_q.delete();
        bus.iLEN1 = 4'd0; bus.iREQ1 = 1'b1;
        @(negedge clk);
        chk("l0_grant", bus.oGRANT, 2'b10);
        chk("l0_done_early", bus.oDONE1, 1'b0);
        @(negedge clk);
        chk("l0_done", bus.oDONE1, 1'b1);
        bus.iREQ1 = 1'b0;
        @(negedge clk);
        chk("l0_grant_clr", bus.oGRANT, 2'b00);
        chk("l0_nostart", cap_q.size(), 0);
        @(negedge clk);
        model_last = 1;

        // Start timeout: transmitter never goes busy
        tx_on = 1'b0;
        cap_q.delete();
        bus.iDATA0 = 64'h1234567890ABCDEF; bus.iLEN0 = 4'd4; bus.iREQ0 = 1'b1;
        cyc = 0;
        while (!bus.oTXD_Start && cyc < 20) begin @(negedge clk); cyc++; end
        chk("tmo_start", cyc, 3);
        repeat (15) @(negedge clk);
        chk("tmo_err_early", bus.oERR, 1'b0);
        @(negedge clk);
        chk("tmo_err", bus.oERR, 1'b1);
        chk("tmo_done", bus.oDONE0, 1'b1);
        bus.iREQ0 = 1'b0;
        tx_on = 1'b1;
        @(negedge clk);
        chk("tmo_bytes", cap_q.size(), 1);
        model_last = 0;
        xfer(1'b0, 1'b1, 64'h0, 64'h5566778899AABBCC, 4'd0, 4'd3, f, nb);
        chk("post_tmo_nb", nb, 3 + CS);
        chk("err_sticky", bus.oERR, 1'b1);

        // Reset in the middle of byte 3 of 8
        cap_q.delete();
        @(negedge clk);
        bus.iDATA0 = 64'h0102030405060708; bus.iLEN0 = 4'd8; bus.iREQ0 = 1'b1;
        cyc = 0;
        while (cap_q.size() < 3 && cyc < 200) begin @(negedge clk); cyc++; end
        chk("rst_reach3", cap_q.size(), 3);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        bus.iREQ0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_outs", {bus.oGRANT, bus.oTXD_DATA, bus.oTXD_Start,
                         bus.oDONE0, bus.oDONE1, bus.oERR}, 64'd0);
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.oDONE0 || bus.oDONE1) dn++;
        end
        chk("rst_nodone", dn, 0);
        chk("rst_3bytes", cap_q.size(), 3);
        model_last = 1;
        xfer(1'b1, 1'b0, 64'h0102030405060708, 64'h0, 4'd8, 4'd0, f, nb);
        chk("rst_fresh_nb", nb, 8 + CS);

        // Randomized packets
        for (int it = 0; it < 25; it++) begin
            r   = $urandom_range(1, 3);
            rd0 = {$urandom, $urandom};
            rd1 = {$urandom, $urandom};
            rl0 = 4'($urandom_range(0, 15));
            rl1 = 4'($urandom_range(0, 15));
            xfer(r[0], r[1], rd0, rd1, rl0, rl1, f, nb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
